// File: rtl/mac_seq_pkg.sv
// Shared types for the MAC job sequencer: FSM state encoding and the per-beat tag
// that travels alongside the mul->acc datapath.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } mac_seq_state_t;

    // v: beat was a real operand, f: first beat of a reduction,
    // l: last beat of a reduction, j: last beat of the last output of the job
    typedef struct packed {
        logic v;
        logic f;
        logic l;
        logic j;
    } mac_tag_t;

endpackage

// File: rtl/mac_seq_if.sv
// Config, operand and result handshakes of one PE's MAC sequencer, plus the
// control strobes it drives into the mul->acc chain.
interface mac_seq_if #(
    parameter int WC = 16
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [WC-1:0] cfg_k;
    logic [WC-1:0] cfg_n;
    logic          s_valid;
    logic          s_ready;
    logic          mac_en;
    logic          mac_zero;
    logic          mac_first;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;

    modport slave (
        input  cfg_valid, cfg_k, cfg_n, s_valid, m_ready,
        output cfg_ready, s_ready, mac_en, mac_zero, mac_first,
               m_valid, m_last, busy, done
    );

    modport master (
        output cfg_valid, cfg_k, cfg_n, s_valid, m_ready,
        input  cfg_ready, s_ready, mac_en, mac_zero, mac_first,
               m_valid, m_last, busy, done
    );
endinterface

// File: rtl/mac_seq_tag_pipe.sv
// Enabled shift register carrying beat tags in lockstep with the mul->acc chain.
// tap_o is stage TAP (mul output), last_o is the final stage (acc output).
module mac_tag_pipe #(
    parameter int  DEPTH = 2,
    parameter int  TAP   = 1,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  T     d_i,
    output T     tap_o,
    output T     last_o
);

    T pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (en_i) begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tap_o  = pipe_q[TAP-1];
    assign last_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mac_seq.sv
// Job sequencer for one mul->acc MAC chain: frames each job as N outputs of
// K-beat reductions and drives the chain's enable, zero-gate and first strobe.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int LM = 1,
    parameter int LA = 1,
    parameter int WC = 16
) (
    input  logic     clk,
    input  logic     rst,
    mac_seq_if.slave bus
);

    mac_seq_state_t state_q, state_d;
    logic [WC-1:0]  k_q, k_d;
    logic [WC-1:0]  n_q, n_d;
    logic [WC-1:0]  beat_q, beat_d;
    logic [WC-1:0]  outs_in_q, outs_in_d;
    logic [WC-1:0]  outs_out_q, outs_out_d;
    logic           done_q, done_d;

    logic           mac_en;
    logic           s_ready;
    logic           accept;
    logic           m_valid;
    logic           m_hs;
    logic           last_beat;
    logic           last_out;
    mac_tag_t       tag_in;
    mac_tag_t       tag_first;
    mac_tag_t       tag_out;

    // A blocked result freezes the whole chain so y stays put until taken.
    assign mac_en  = !(m_valid && !bus.m_ready);
    assign s_ready = (state_q == RUN) && mac_en;
    assign accept  = bus.s_valid && s_ready;
    assign m_hs    = m_valid && bus.m_ready;

    always_comb begin
        last_beat = (beat_q == k_q - WC'(1));
        last_out  = (outs_in_q == n_q - WC'(1));
        tag_in.v  = accept;
        tag_in.f  = accept && (beat_q == '0);
        tag_in.l  = accept && last_beat;
        tag_in.j  = accept && last_beat && last_out;
    end

    mac_tag_pipe #(
        .DEPTH (LM + LA),
        .TAP   (LM),
        .T     (mac_tag_t)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .en_i   (mac_en),
        .d_i    (tag_in),
        .tap_o  (tag_first),
        .last_o (tag_out)
    );

    assign m_valid = tag_out.v && tag_out.l;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        n_d        = n_q;
        beat_d     = beat_q;
        outs_in_d  = outs_in_q;
        outs_out_d = outs_out_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    k_d        = (bus.cfg_k == '0) ? WC'(1) : bus.cfg_k;
                    n_d        = bus.cfg_n;
                    beat_d     = '0;
                    outs_in_d  = '0;
                    outs_out_d = '0;
                    if (bus.cfg_n == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Earlier outputs can complete while later beats still stream in.
                if (m_hs) begin
                    outs_out_d = outs_out_q + WC'(1);
                end
                if (accept) begin
                    if (last_beat) begin
                        beat_d    = '0;
                        outs_in_d = outs_in_q + WC'(1);
                        if (last_out) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        beat_d = beat_q + WC'(1);
                    end
                end
            end
            DRAIN: begin
                if (m_hs) begin
                    outs_out_d = outs_out_q + WC'(1);
                    if (outs_out_q + WC'(1) == n_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            outs_in_q  <= '0;
            outs_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            outs_in_q  <= outs_in_d;
            outs_out_q <= outs_out_d;
            done_q     <= done_d;
        end
    end

    // Job geometry is only consulted outside IDLE, after a config has loaded it.
    always_ff @(posedge clk) begin
        k_q <= k_d;
        n_q <= n_d;
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.s_ready   = s_ready;
    assign bus.mac_en    = mac_en;
    assign bus.mac_zero  = !accept;
    assign bus.mac_first = tag_first.v && tag_first.f;
    assign bus.m_valid   = m_valid;
    assign bus.m_last    = tag_out.j;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule
